// File: rtl/dff_pkg.sv
// dff_pkg: mode encodings shared by the pipeline, its pin mapping and the testbench
package dff_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_CLEAR  = 2'b10;
    localparam logic [1:0] MODE_CHANGE = 2'b11;

endpackage

// File: rtl/dff_stage.sv
// dff_stage: one WIDTH-bit pipeline register with sync active-low reset, clear and load
module dff_stage #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!reset_n || clr_i) data_q <= '0;
        else if (load_i)       data_q <= d_i;
    end

    assign q_o = data_q;

endmodule

// File: rtl/dff_pipeline.sv
// dff_pipeline: DEPTH-stage WIDTH-bit delay line with hold/shift/clear/shift-on-change modes,
// selectable output tap and saturating fill tracking.
module dff_pipeline
    import dff_pkg::*;
#(
    parameter  int WIDTH  = 6,
    parameter  int DEPTH  = 4,
    localparam int TAP_W  = $clog2(DEPTH),
    localparam int FILL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  d,
    input  logic [TAP_W-1:0]  tap_sel,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  q_last,
    output logic [FILL_W-1:0] fill,
    output logic              full,
    output logic              changed
);

    logic [WIDTH-1:0]  stage_q [DEPTH];
    logic [WIDTH-1:0]  stage_d [DEPTH];
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              changed_q, changed_d;
    logic              shift, clear;

    // An empty pipe always accepts the first CHANGE sample, even if it equals stage 0's zero.
    always_comb begin
        clear     = mode == MODE_CLEAR;
        shift     = en && (mode == MODE_SHIFT ||
                    (mode == MODE_CHANGE && (fill_q == '0 || d != stage_q[0])));
        fill_d    = clear ? '0 : ((shift && fill_q != FILL_W'(DEPTH)) ? fill_q + FILL_W'(1) : fill_q);
        changed_d = shift && mode == MODE_CHANGE;
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        dff_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .load_i  (shift),
            .clr_i   (clear),
            .d_i     (stage_d[i]),
            .q_o     (stage_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fill_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            fill_q    <= fill_d;
            changed_q <= changed_d;
        end
    end

    assign q       = (int'(tap_sel) < DEPTH) ? stage_q[tap_sel] : '0;
    assign q_last  = stage_q[DEPTH-1];
    assign fill    = fill_q;
    assign full    = fill_q == FILL_W'(DEPTH);
    assign changed = changed_q;

endmodule

// File: tb/tb_dff_pipeline.sv
// tb_dff_pipeline: directed and randomized checks of dff_pipeline against a history-list model
module tb_dff_pipeline;
    import dff_pkg::*;

    localparam int W = 6;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = MODE_HOLD;
    logic [W-1:0] d = '0;
    logic [1:0]   tap_sel = '0;
    logic [W-1:0] q, q_last;
    logic [2:0]   fill;
    logic         full, changed;

    int errors = 0;
    int checks = 0;
    int m_st[D];
    int m_fill;
    int m_chg;

    dff_pipeline #(.WIDTH(W), .DEPTH(D)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .mode    (mode),
        .d       (d),
        .tap_sel (tap_sel),
        .q       (q),
        .q_last  (q_last),
        .fill    (fill),
        .full    (full),
        .changed (changed)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: the pipe is the list of the most recent accepted samples, newest first.
    task automatic model_edge(input bit r, input bit e, input logic [1:0] m, input int dv);
        bit take;
        if (!r || m == MODE_CLEAR) begin
            foreach (m_st[i]) m_st[i] = 0;
            m_fill = 0;
            m_chg  = 0;
        end else begin
            take = e && (m == MODE_SHIFT || (m == MODE_CHANGE && (m_fill == 0 || dv != m_st[0])));
            if (take) begin
                for (int i = D - 1; i > 0; i--) m_st[i] = m_st[i-1];
                m_st[0] = dv;
                m_fill  = (m_fill + 1 > D) ? D : m_fill + 1;
            end
            m_chg = (take && m == MODE_CHANGE) ? 1 : 0;
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [1:0] m, input logic [W-1:0] dv);
        @(negedge clk);
        reset_n = r;
        en      = e;
        mode    = m;
        d       = dv;
        @(posedge clk);
        model_edge(r, e, m, int'(dv));
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"}, 32'(q), m_st[tap_sel]);
        chk({tag, ".q_last"}, 32'(q_last), m_st[D-1]);
        chk({tag, ".fill"}, 32'(fill), m_fill);
        chk({tag, ".full"}, 32'(full), (m_fill == D) ? 1 : 0);
        chk({tag, ".changed"}, 32'(changed), m_chg);
    endtask

    task automatic sweep(input string tag, input int e0, input int e1, input int e2, input int e3);
        int ev[D];
        ev = '{e0, e1, e2, e3};
        for (int t = 0; t < D; t++) begin
            tap_sel = 2'(t);
            #1;
            chk($sformatf("%s.tap%0d", tag, t), 32'(q), ev[t]);
        end
        tap_sel = '0;
    endtask

    initial begin
        foreach (m_st[i]) m_st[i] = 0;
        m_fill = 0;
        m_chg  = 0;

        step(1'b0, 1'b1, MODE_SHIFT, 6'h15);
        check_all("reset");
        chk("reset.fill_const", 32'(fill), 0);

        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1, MODE_SHIFT, W'(i));
            check_all($sformatf("shift%0d", i));
            chk($sformatf("shift%0d.fill_const", i), 32'(fill), (i > 4) ? 4 : i);
            chk($sformatf("shift%0d.full_const", i), 32'(full), (i >= 4) ? 1 : 0);
        end
        sweep("shift_stages", 'h05, 'h04, 'h03, 'h02);
        chk("shift.q_last_const", 32'(q_last), 'h02);

        step(1'b1, 1'b0, MODE_CLEAR, '0);
        step(1'b1, 1'b1, MODE_SHIFT, 6'h11);
        step(1'b1, 1'b0, MODE_SHIFT, 6'h22);
        check_all("en_off");
        step(1'b1, 1'b1, MODE_SHIFT, 6'h33);
        sweep("en_toggle", 'h33, 'h11, 0, 0);
        chk("en_toggle.fill", 32'(fill), 2);

        step(1'b1, 1'b1, MODE_CLEAR, '0);
        step(1'b1, 1'b1, MODE_CHANGE, 6'h0A);
        chk("chg1", 32'(changed), 1);
        step(1'b1, 1'b1, MODE_CHANGE, 6'h0A);
        chk("chg2", 32'(changed), 0);
        step(1'b1, 1'b1, MODE_CHANGE, 6'h0B);
        chk("chg3", 32'(changed), 1);
        step(1'b1, 1'b1, MODE_CHANGE, 6'h0B);
        chk("chg4", 32'(changed), 0);
        check_all("change");
        sweep("change", 'h0B, 'h0A, 0, 0);
        chk("change.fill", 32'(fill), 2);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, MODE_SHIFT, W'(8 + i));
        chk("prefill.full", 32'(full), 1);
        step(1'b1, 1'b0, MODE_CLEAR, 6'h3F);
        check_all("clear");
        sweep("clear", 0, 0, 0, 0);
        step(1'b1, 1'b1, MODE_SHIFT, 6'h3F);
        check_all("post_clear");
        chk("post_clear.fill", 32'(fill), 1);
        chk("post_clear.q", 32'(q), 'h3F);

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, MODE_SHIFT, W'(20 + i));
        step(1'b0, 1'b1, MODE_SHIFT, 6'h2A);
        check_all("midreset");
        sweep("midreset", 0, 0, 0, 0);
        step(1'b1, 1'b1, MODE_HOLD, 6'h01);
        check_all("hold");
        step(1'b1, 1'b1, MODE_CHANGE, 6'h00);
        chk("empty_change", 32'(changed), 1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, MODE_SHIFT, W'(i + 1));
        sweep("post_reset", 3, 2, 1, 0);

        for (int n = 0; n < 400; n++) begin
            tap_sel = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), W'($urandom_range(0, 3)));
            check_all($sformatf("rand%0d", n));
            if (n % 50 == 0) sweep($sformatf("rand%0d", n), m_st[0], m_st[1], m_st[2], m_st[3]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
